// File: rtl/sa_output_drain.sv
// Output drain for sa_matmul: deskews the column-skewed psum stream, narrows each column and writes one row per word.
// Optional feature macro SA_DRAIN_SAT_EN selects signed saturation instead of two's-complement truncation.
module sa_output_drain #(
  parameter int NUM_COLS      = 4,
  parameter int ADD_DATAWIDTH = 8,
  parameter int OUT_DATAWIDTH = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_start,
  input  logic [CNT_WIDTH-1:0]              i_num_rows,
  input  logic [ADDR_WIDTH-1:0]             i_base_addr,
  input  logic                              i_valid,
  input  logic [NUM_COLS*ADD_DATAWIDTH-1:0] i_psum,
  output logic                              o_wr_en,
  output logic [ADDR_WIDTH-1:0]             o_wr_addr,
  output logic [NUM_COLS*OUT_DATAWIDTH-1:0] o_wr_data,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_overflow
);

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;

  state_t                            state_q, state_d;
  logic [CNT_WIDTH-1:0]              num_q, num_d;
  logic [CNT_WIDTH-1:0]              rows_in_q, rows_in_d;
  logic [CNT_WIDTH-1:0]              wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
  logic                              ovf_q, ovf_d;
  logic                              accept;
  logic [NUM_COLS-2:0]               vld_q, vld_d;
  logic                              vld_out;
  logic                              wr_en_q;
  logic [ADDR_WIDTH-1:0]             wr_addr_q;
  logic [NUM_COLS*OUT_DATAWIDTH-1:0] wr_data_q, wr_data_d;
  logic signed [ADD_DATAWIDTH-1:0]   algn [NUM_COLS];

`ifdef SA_DRAIN_SAT_EN
  localparam logic signed [ADD_DATAWIDTH-1:0] SAT_MAX =
    {{(ADD_DATAWIDTH-OUT_DATAWIDTH+1){1'b0}}, {(OUT_DATAWIDTH-1){1'b1}}};
  localparam logic signed [ADD_DATAWIDTH-1:0] SAT_MIN =
    {{(ADD_DATAWIDTH-OUT_DATAWIDTH+1){1'b1}}, {(OUT_DATAWIDTH-1){1'b0}}};
`endif

  function automatic logic signed [OUT_DATAWIDTH-1:0] reduce(input logic signed [ADD_DATAWIDTH-1:0] x);
`ifdef SA_DRAIN_SAT_EN
    if (x > SAT_MAX)      reduce = SAT_MAX[OUT_DATAWIDTH-1:0];
    else if (x < SAT_MIN) reduce = SAT_MIN[OUT_DATAWIDTH-1:0];
    else                  reduce = x[OUT_DATAWIDTH-1:0];
`else
    reduce = x[OUT_DATAWIDTH-1:0];
`endif
  endfunction

  // Deskew: column c waits NUM_COLS-1-c cycles so every column lines up with the last one.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    localparam int D = NUM_COLS - 1 - c;
    if (D == 0) begin : g_pass
      assign algn[c] = i_psum[c*ADD_DATAWIDTH +: ADD_DATAWIDTH];
    end else begin : g_dly
      logic signed [ADD_DATAWIDTH-1:0] sk_q [D];
      always_ff @(posedge clk) begin
        sk_q[0] <= i_psum[c*ADD_DATAWIDTH +: ADD_DATAWIDTH];
        for (int k = 1; k < D; k++) sk_q[k] <= sk_q[k-1];
      end
      assign algn[c] = sk_q[D-1];
    end
  end

  always_comb begin
    vld_d[0] = accept;
    for (int k = 1; k < NUM_COLS - 1; k++) vld_d[k] = vld_q[k-1];
  end

  assign vld_out = vld_q[NUM_COLS-2];

  always_comb begin
    wr_data_d = '0;
    for (int c = 0; c < NUM_COLS; c++) wr_data_d[c*OUT_DATAWIDTH +: OUT_DATAWIDTH] = reduce(algn[c]);
  end

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    rows_in_d = rows_in_q;
    wr_cnt_d  = wr_cnt_q;
    addr_d    = addr_q;
    ovf_d     = ovf_q;
    accept    = 1'b0;
    if (wr_en_q) wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
    if (vld_out) addr_d = addr_q + ADDR_WIDTH'(1);
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_num_rows == '0) begin
            state_d = DONE;
          end else begin
            num_d     = i_num_rows;
            rows_in_d = '0;
            wr_cnt_d  = '0;
            addr_d    = i_base_addr;
            ovf_d     = 1'b0;
            state_d   = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (i_valid) begin
          accept    = 1'b1;
          rows_in_d = rows_in_q + CNT_WIDTH'(1);
          if (rows_in_q + CNT_WIDTH'(1) == num_q) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (i_valid) ovf_d = 1'b1;
        if (wr_en_q && (wr_cnt_q + CNT_WIDTH'(1) == num_q)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output stage: registered write port, one row per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      num_q     <= '0;
      rows_in_q <= '0;
      wr_cnt_q  <= '0;
      addr_q    <= '0;
      ovf_q     <= 1'b0;
      vld_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      rows_in_q <= rows_in_d;
      wr_cnt_q  <= wr_cnt_d;
      addr_q    <= addr_d;
      ovf_q     <= ovf_d;
      vld_q     <= vld_d;
      wr_en_q   <= vld_out;
      if (vld_out) begin
        wr_addr_q <= addr_q;
        wr_data_q <= wr_data_d;
      end
    end
  end

  assign o_wr_en    = wr_en_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_busy     = (state_q != IDLE);
  assign o_done     = (state_q == DONE);
  assign o_overflow = ovf_q;

endmodule
